// File: rtl/case2_iter_sched_pkg.sv
// rtl/case2_iter_sched_pkg.sv - shared state encoding and width helpers for case2_iter_sched
package case2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_H,
    LOAD_A,
    WAIT_CORE,
    FINISH
  } state_t;

  // Counter width able to hold the value n itself, not just n-1.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int J_DEF   = 14;
  localparam int I_DEF   = 7;
  localparam int A_DEF   = 2;
  localparam int J_WIDTH = cnt_w(J_DEF);
  localparam int A_WIDTH = cnt_w(A_DEF);
  localparam int I_WIDTH = cnt_w(I_DEF);

endpackage

// File: rtl/case2_iter_sched_skid.sv
// rtl/case2_iter_sched_skid.sv - stream_skid2: 2-entry fall-through FIFO with a next-cycle credit
module stream_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         credit,
  output logic [W-1:0] tdata,
  output logic         tvalid,
  input  logic         tready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         pop;
  logic [2:0]   occ_after;

  // An arriving beat is presented in the same cycle when the FIFO is empty.
  assign tvalid    = (cnt != 2'd0) | push;
  assign pop       = tvalid & tready;
  assign tdata     = (cnt != 2'd0) ? mem[rd_ptr] : (push ? push_data : '0);
  assign occ_after = {1'b0, cnt} + {2'b00, push} - {2'b00, pop};
  assign credit    = occ_after <= 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/case2_iter_sched.sv
// rtl/case2_iter_sched.sv - iteration sequencer feeding H rows and alpha_u columns to the case-2 core; optional watchdog under CASE2_SCHED_WDOG_EN
module case2_iter_sched
  import case2_pkg::*;
#(
  parameter int J       = 14,
  parameter int I       = 7,
  parameter int A       = 2,
  parameter int ITER    = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      h_rd_en,
  output logic [$clog2(J):0]        h_rd_addr,
  input  logic [I-1:0]              h_rd_data,
  output logic                      a_rd_en,
  output logic [$clog2(A*J):0]      a_rd_addr,
  input  logic [DW-1:0]             a_rd_data,
  output logic [I-1:0]              H_row,
  output logic                      H_row_tvalid,
  input  logic                      H_row_tready,
  output logic                      H_row_tlast,
  output logic [DW-1:0]             alpha_u_col,
  output logic                      alpha_u_col_tvalid,
  input  logic                      alpha_u_col_tready,
  output logic                      alpha_u_col_tlast,
  input  logic                      core_done,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(ITER):0]     iter_cnt,
  output logic                      err
);

  localparam int JW = cnt_w(J);
  localparam int AW = cnt_w(A * J);
  localparam int CW = cnt_w(A);
  localparam int IW = cnt_w(ITER);
  localparam logic [JW-1:0] J_CNT     = JW'(J);
  localparam logic [JW-1:0] J_LAST    = JW'(J - 1);
  localparam logic [AW-1:0] AJ_CNT    = AW'(A * J);
  localparam logic [CW-1:0] A_LAST    = CW'(A - 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(ITER - 1);

  if (ITER < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("case2_iter_sched: ITER and TIMEOUT must be >= 1");
  end

  state_t         state, state_nx;
  logic [JW-1:0]  h_addr, a_row;
  logic [AW-1:0]  a_addr;
  logic [CW-1:0]  a_col;
  logic           h_push, h_last_q, h_credit;
  logic           a_push, a_last_q, a_credit;
  logic [I:0]     h_tdata;
  logic [DW:0]    a_tdata;
  logic           h_acc_last, a_acc_last, a_final;

  assign h_rd_en   = (state == LOAD_H) && (h_addr != J_CNT) && h_credit;
  assign a_rd_en   = (state == LOAD_A) && (a_addr != AJ_CNT) && a_credit;
  assign h_rd_addr = h_addr;
  assign a_rd_addr = a_addr;

  stream_skid2 #(.W(I + 1)) u_h_skid (
    .clk(clk), .rst_n(rst_n), .push(h_push), .push_data({h_rd_data, h_last_q}),
    .credit(h_credit), .tdata(h_tdata), .tvalid(H_row_tvalid), .tready(H_row_tready)
  );

  stream_skid2 #(.W(DW + 1)) u_a_skid (
    .clk(clk), .rst_n(rst_n), .push(a_push), .push_data({a_rd_data, a_last_q}),
    .credit(a_credit), .tdata(a_tdata), .tvalid(alpha_u_col_tvalid), .tready(alpha_u_col_tready)
  );

  assign H_row             = h_tdata[I:1];
  assign H_row_tlast       = h_tdata[0];
  assign alpha_u_col       = a_tdata[DW:1];
  assign alpha_u_col_tlast = a_tdata[0];
  assign h_acc_last        = H_row_tvalid & H_row_tready & H_row_tlast;
  assign a_acc_last        = alpha_u_col_tvalid & alpha_u_col_tready & alpha_u_col_tlast;
  assign a_final           = a_acc_last && (a_col == A_LAST);
  assign busy              = (state != IDLE);
  assign done              = (state == FINISH);

`ifdef CASE2_SCHED_WDOG_EN
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_expire;

  assign wd_expire = (state == WAIT_CORE) && !core_done && (wd_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT_CORE) ? wd_cnt + TW'(1) : '0;
      if (wd_expire) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = LOAD_H;
      LOAD_H:    if (h_acc_last) state_nx = LOAD_A;
      LOAD_A:    if (a_final) state_nx = WAIT_CORE;
      WAIT_CORE: begin
        if (core_done) state_nx = (iter_cnt == ITER_LAST) ? FINISH : LOAD_H;
`ifdef CASE2_SCHED_WDOG_EN
        else if (wd_expire) state_nx = IDLE;
`endif
      end
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      iter_cnt <= '0;
      h_addr   <= '0;
      h_push   <= 1'b0;
      h_last_q <= 1'b0;
      a_addr   <= '0;
      a_row    <= '0;
      a_col    <= '0;
      a_push   <= 1'b0;
      a_last_q <= 1'b0;
    end else begin
      state    <= state_nx;
      h_push   <= h_rd_en;
      h_last_q <= h_rd_en && (h_addr == J_LAST);
      a_push   <= a_rd_en;
      a_last_q <= a_rd_en && (a_row == J_LAST);
      if (state == IDLE && start) iter_cnt <= '0;
      else if (state == WAIT_CORE && core_done && iter_cnt != ITER_LAST) iter_cnt <= iter_cnt + IW'(1);
      if (state != LOAD_H) h_addr <= '0;
      else if (h_rd_en) h_addr <= h_addr + JW'(1);
      // Column/row trackers restart on every LOAD_A entry.
      if (state != LOAD_A) begin
        a_addr <= '0;
        a_row  <= '0;
        a_col  <= '0;
      end else begin
        if (a_rd_en) begin
          a_addr <= a_addr + AW'(1);
          a_row  <= (a_row == J_LAST) ? '0 : a_row + JW'(1);
        end
        if (a_acc_last) a_col <= a_col + CW'(1);
      end
    end
  end

endmodule
